// File: rtl/issue_stage_pkg.sv
// Shared types and constants for the issue stage.
//   DEF_NUM_REGS    : default architectural register count
//   REG_IDX_W       : width of a register index
//   decoded_instr_t : decoded instruction as it leaves the dispatch queue
package issue_stage_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int REG_IDX_W    = $clog2(DEF_NUM_REGS);

  typedef struct packed {
    logic [7:0]           opcode;
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_valid;
    logic [REG_IDX_W-1:0] rs1;
    logic                 rs1_valid;
    logic [REG_IDX_W-1:0] rs2;
    logic                 rs2_valid;
    logic [31:0]          imm;
  } decoded_instr_t;

endpackage

// File: rtl/issue_stage_scoreboard.sv
// Per-register pending scoreboard.
//   clk, rst_n          : clock, synchronous active-high reset
//   set_en_i, set_idx_i : mark a destination register pending (issue)
//   clr_en_i, clr_idx_i : clear a pending register (writeback)
//   eff_pending_o       : pending vector with this cycle's writeback already
//                         removed, so the hazard check sees the bypass
module issue_stage_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en_i,
  input  logic [IDX_W-1:0]    set_idx_i,
  input  logic                clr_en_i,
  input  logic [IDX_W-1:0]    clr_idx_i,
  output logic [NUM_REGS-1:0] eff_pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    // x0 is hardwired; it is never tracked as pending.
    if (set_en_i && (set_idx_i != '0)) set_mask[set_idx_i] = 1'b1;
    if (clr_en_i) clr_mask[clr_idx_i] = 1'b1;
  end

  assign eff_pending_o = pending_q & ~clr_mask;
  // Set is applied after clear: a new writer of the same register wins.
  assign pending_d     = eff_pending_o | set_mask;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/issue_stage.sv
// In-order issue stage.
//   clk, rst_n        : clock, synchronous active-high reset (1 = reset)
//   disp_instr        : dispatch queue head
//   disp_empty        : dispatch queue empty flag
//   disp_r_en         : pop strobe, high exactly on issue-fire cycles
//   wb_valid, wb_rd   : writeback that clears a pending register
//   flush             : squash the output register, block issue
//   iss_valid/ready   : valid/ready handshake toward execute; a transfer
//                       happens on a cycle where both are high. While
//                       iss_valid && !iss_ready the output holds stable
//                       (flush excepted).
//   iss_instr         : issued instruction
//   stall_cycles      : saturating count of cycles the head was blocked
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int STALL_CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  decoded_instr_t               disp_instr,
  input  logic                         disp_empty,
  output logic                         disp_r_en,
  input  logic                         wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0]  wb_rd,
  input  logic                         flush,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output decoded_instr_t               iss_instr,
  output logic [STALL_CNT_W-1:0]       stall_cycles
);

  logic [NUM_REGS-1:0]    eff_pending;
  logic                   hazard;
  logic                   rd_writes;
  logic                   out_free;
  logic                   fire;
  logic                   stall_inc;

  logic                   iss_valid_q;
  decoded_instr_t         iss_instr_q;
  logic [STALL_CNT_W-1:0] stall_q;

  issue_stage_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    ($clog2(NUM_REGS))
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_en_i      (fire && rd_writes),
    .set_idx_i     (disp_instr.rd),
    .clr_en_i      (wb_valid),
    .clr_idx_i     (wb_rd),
    .eff_pending_o (eff_pending)
  );

  assign rd_writes = disp_instr.rd_valid && (disp_instr.rd != '0);

  // Hazard check against the bypassed pending vector.
  always_comb begin
    hazard = 1'b0;
    if (disp_instr.rs1_valid && eff_pending[disp_instr.rs1]) hazard = 1'b1;
    if (disp_instr.rs2_valid && eff_pending[disp_instr.rs2]) hazard = 1'b1;
    if (rd_writes && eff_pending[disp_instr.rd])             hazard = 1'b1;
  end

  assign out_free  = !iss_valid_q || iss_ready;
  // Reset gating keeps the queue from being popped while in reset.
  assign fire      = !rst_n && !disp_empty && !hazard && out_free && !flush;
  assign disp_r_en = fire;
  assign stall_inc = !disp_empty && !fire && !flush;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      iss_valid_q <= 1'b0;
      iss_instr_q <= '0;
    end else if (flush) begin
      iss_valid_q <= 1'b0;
    end else if (fire) begin
      iss_valid_q <= 1'b1;
      iss_instr_q <= disp_instr;
    end else if (iss_ready) begin
      iss_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign iss_valid    = iss_valid_q;
  assign iss_instr    = iss_instr_q;
  assign stall_cycles = stall_q;

endmodule

// File: doc/issue_stage.md
# issue_stage

In-order issue stage that consumes the dispatch queue head, checks it against a per-register pending scoreboard, and launches hazard-free instructions into a one-entry output register toward the execute stage. It pops the dispatch queue through that queue's `r_en`/`empty` interface and receives register writebacks to clear pending state. It also keeps a saturating count of head-blocked cycles for performance analysis.

## Interface
- `NUM_REGS`, 32, architectural register count; scoreboard width.
- `STALL_CNT_W`, 32, width of the stall counter.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  synchronous, active-high reset (port keeps the codebase name `rst_n`; asserted = 1).
- `disp_instr`  in  decoded_instr_t  dispatch queue head (`instr_out` of the queue).
- `disp_empty`  in  1  dispatch queue empty flag.
- `disp_r_en`  out  1  pop strobe to the queue; high exactly on issue-fire cycles.
- `wb_valid`  in  1  writeback strobe from execute/commit.
- `wb_rd`  in  $clog2(NUM_REGS)  register being written back.
- `flush`  in  1  squash the output register; block issue this cycle.
- `iss_valid`  out  1  output register holds an instruction.
- `iss_ready`  in  1  execute stage accepts `iss_instr` this cycle.
- `iss_instr`  out  decoded_instr_t  issued instruction.
- `stall_cycles`  out  STALL_CNT_W  saturating count of blocked cycles.

## Operation
- Scoreboard: `pending[NUM_REGS-1:0]`. Bit 0 is never set.
- The hazard check uses the `decoded_instr_t` fields `rs1`, `rs2`, `rd` and the valid bits `rs1_valid`, `rs2_valid`, `rd_valid`. These fields are mandatory in `define.svh`.
- `eff_pending` = `pending` with bit `wb_rd` cleared when `wb_valid` is high. This is a same-cycle writeback bypass.
- `hazard` is true when any of the following holds:
  - `rs1_valid` and `eff_pending[rs1]` (RAW);
  - `rs2_valid` and `eff_pending[rs2]` (RAW);
  - `rd_valid` and `rd != 0` and `eff_pending[rd]` (WAW).
- `out_free` = `!iss_valid || iss_ready`.
- `fire` = `!disp_empty && !hazard && out_free && !flush`. `disp_r_en` = `fire` (combinational).
- On `fire`:
  - `iss_instr <= disp_instr`, `iss_valid <= 1`.
  - If `rd_valid && rd != 0`, set `pending[rd]`.
- When there is no fire and `iss_ready` is high, `iss_valid <= 0`.
- `flush` forces `iss_valid <= 0` and overrides everything else that cycle. The scoreboard is untouched by flush, because in-flight instructions still write back.
- Scoreboard update each cycle: `pending <= (pending & ~wb_clear) | fire_set`. When set and clear hit the same register, the set wins.
- Stall counter:
  - Increments when `!disp_empty && !fire && !flush`.
  - Saturates at all-ones and never wraps.

## Timing
- Reset (`rst_n` = 1 at posedge):
  - `iss_valid` = 0, `iss_instr` = 0, `pending` = 0, `stall_cycles` = 0.
  - `disp_r_en` = 0 while reset is asserted.
- Reset mid-operation drops any held instruction and all pending bits. There are no partial updates in the reset cycle.
- Latency: queue head visible at cycle N with `fire` → `iss_valid` = 1 at N+1.
- Throughput: one issue per cycle when hazard-free and `iss_ready` is held high.
- Handshake: `iss_instr` and `iss_valid` stay stable while `iss_valid && !iss_ready`, unless `flush` is asserted.
- Writeback on cycle N to a register blocking the head lets the head fire in cycle N (bypass).
- Empty queue: `disp_r_en` = 0; `stall_cycles` does not count.
- Full queue has no special handling here.
- `wb_rd` = 0 is a no-op.
- `wb_valid` on a non-pending register is a no-op.

## Structure
- `decoded_instr_t` register fields (`rs1`, `rs2`, `rd`, and their valid bits) live in `define.svh`.
- Add `REG_IDX_W = $clog2(NUM_REGS)` to `define.svh` as a shared constant.
- One sub-module is natural: `scoreboard`. It holds the pending vector and provides:
  - set/clear ports;
  - combinational `eff_pending` output.
- `issue_stage` holds the hazard logic, the output register and the stall counter.

## Test plan
- Reset then push `ADD` x1←x2,x3 → `disp_r_en` high same cycle; `iss_valid` = 1 next cycle; `pending[1]` = 1.
- Back-to-back `x1←x2`, `x4←x1`, no writeback → second instruction is held; `stall_cycles` rises by 1 per cycle. Then `wb_valid`=1, `wb_rd`=1 → second instruction fires in that same cycle.
- WAW: `x5←…` issued, then `x5←…` at head → blocked until `wb_rd`=5. Fire on the same cycle as that writeback must leave `pending[5]` = 1.
- `iss_ready` = 0 for 3 cycles with a valid output → `iss_instr` stable, `disp_r_en` = 0. Raise `iss_ready` → next instruction issues one per cycle.
- `flush` with `iss_valid` = 1 and head ready → `iss_valid` = 0 next cycle, no pop that cycle, `pending` unchanged.
- Force the counter to all-ones with a continuous stall → `stall_cycles` holds all-ones. Writes to `rd` = x0 never set `pending[0]` and never stall.
